// File: rtl/serv_dbus_pkg.sv
// Shared constants for the SERV data-bus RAM responder.
//  - FSM state encoding (IDLE / WAIT / ACK)
//  - width of the wait-state counter
//  - number of byte lanes on the 32-bit bus
package serv_dbus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam int WCNT_W    = 4;
  localparam int NUM_LANES = 4;

endpackage

// File: rtl/serv_dbus_ram_mem.sv
// Single-port 2**AW x 32 data RAM with per-byte write enables.
// Ports:
//  i_clk   clock
//  i_re    read enable; o_rdat is loaded from i_addr on the rising edge
//  i_we    per-lane write enables, bit n writes i_wdat[8n+7:8n]
//  i_addr  word address
//  i_wdat  write data
//  o_rdat  registered read data (old contents on a read-during-write)
// No reset: the contents and the read register power up undefined.
import serv_dbus_pkg::*;

module serv_dbus_ram_mem #(
  parameter int AW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_re,
  input  logic [NUM_LANES-1:0] i_we,
  input  logic [AW-1:0]        i_addr,
  input  logic [31:0]          i_wdat,
  output logic [31:0]          o_rdat
);

  localparam int DEPTH = 1 << AW;

  // One byte-wide array per lane keeps each lane a plain inferable memory.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_we[gi]) begin
        lane_mem[i_addr] <= i_wdat[8*gi +: 8];
      end
      if (i_re) begin
        o_rdat[8*gi +: 8] <= lane_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/serv_dbus_ram.sv
// Wishbone-classic data-bus responder for the SERV core.
// A request is captured when it leaves IDLE, optionally waits WAIT cycles,
// then spends one ACK cycle accessing the RAM; the registered ack (and oor)
// is visible in the following cycle.
// Ports:
//  i_clk, i_rst          clock, synchronous active-high reset
//  i_wb_adr/dat/sel/we   request fields (adr[1:0] ignored)
//  i_wb_cyc              request valid, held by the master until ack
//  o_wb_rdt              read data, valid in the ack cycle, held until next read ack
//  o_wb_ack              single-cycle completion strobe
//  o_oor                 out-of-range flag, coincident with ack
import serv_dbus_pkg::*;

module serv_dbus_ram #(
  parameter int          AW   = 8,
  parameter logic [31:0] BASE = 32'h0,
  parameter int          WAIT = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_oor
);

  logic [1:0]        state_reg;
  logic [WCNT_W-1:0] cnt_reg;
  logic [AW-1:0]     idx_reg;
  logic [31:0]       dat_reg;
  logic [3:0]        sel_reg;
  logic              we_reg;
  logic              hit_reg;
  logic              ack_reg;
  logic              oor_reg;
  logic [31:0]       rdt_reg;
  // High in the ack cycle of an in-range read: the RAM output register
  // holds the word, so it is forwarded directly and copied into rdt_reg.
  logic              mem_sel_reg;

  logic              hit;
  logic [3:0]        mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              unused_adr;

  assign hit        = (i_wb_adr[31:AW+2] == BASE[31:AW+2]);
  assign unused_adr = &{1'b0, i_wb_adr[1:0]};

  // Gated by reset so a write caught in ACK by a reset is not committed.
  assign mem_re = (state_reg == ST_ACK);
  assign mem_we = (mem_re && we_reg && hit_reg && !i_rst) ? sel_reg : 4'b0000;

  serv_dbus_ram_mem #(.AW(AW)) u_mem (
    .i_clk  (i_clk),
    .i_re   (mem_re),
    .i_we   (mem_we),
    .i_addr (idx_reg),
    .i_wdat (dat_reg),
    .o_rdat (mem_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      dat_reg     <= '0;
      sel_reg     <= '0;
      we_reg      <= 1'b0;
      hit_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      oor_reg     <= 1'b0;
      rdt_reg     <= '0;
      mem_sel_reg <= 1'b0;
    end else begin
      ack_reg     <= 1'b0;
      oor_reg     <= 1'b0;
      mem_sel_reg <= 1'b0;
      if (mem_sel_reg) begin
        rdt_reg <= mem_rdata;
      end
      case (state_reg)
        ST_IDLE: begin
          // cyc still high during the ack cycle belongs to the finished request.
          if (i_wb_cyc && !ack_reg) begin
            idx_reg <= i_wb_adr[AW+1:2];
            dat_reg <= i_wb_dat;
            sel_reg <= i_wb_sel;
            we_reg  <= i_wb_we;
            hit_reg <= hit;
            if (WAIT > 0) begin
              state_reg <= ST_WAIT;
              cnt_reg   <= WCNT_W'(WAIT - 1);
            end else begin
              state_reg <= ST_ACK;
            end
          end
        end
        ST_WAIT: begin
          if (!i_wb_cyc) begin
            state_reg <= ST_IDLE;
          end else if (cnt_reg == '0) begin
            state_reg <= ST_ACK;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
          ack_reg   <= 1'b1;
          oor_reg   <= !hit_reg;
          if (!we_reg) begin
            if (hit_reg) begin
              mem_sel_reg <= 1'b1;
            end else begin
              rdt_reg <= 32'h0;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_wb_rdt = mem_sel_reg ? mem_rdata : rdt_reg;
  assign o_wb_ack = ack_reg;
  assign o_oor    = oor_reg;

endmodule

// File: tb/tb_serv_dbus_ram.sv
module tb_serv_dbus_ram;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc0;
  logic        cyc3;
  logic [31:0] rdt0;
  logic [31:0] rdt3;
  logic        ack0;
  logic        ack3;
  logic        oor0;
  logic        oor3;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serv_dbus_ram #(.AW(8), .BASE(32'h0), .WAIT(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc0), .o_wb_rdt(rdt0), .o_wb_ack(ack0), .o_oor(oor0)
  );

  serv_dbus_ram #(.AW(8), .BASE(32'h0), .WAIT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc3), .o_wb_rdt(rdt3), .o_wb_ack(ack3), .o_oor(oor3)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rdt;  // read result, or the held value after a write
    logic        exp_oor;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_ack(input bit u3);
    return u3 ? ack3 : ack0;
  endfunction

  // Issue one request just after a rising edge; returns the number of edges
  // (counting the edge that samples cyc as 1) until ack is seen, or -1.
  // Drops cyc in the ack cycle, leaving time one ns after the ack edge.
  task automatic xact(input bit u3, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, output int lat);
    adr = a; dat = d; sel = s; we = w;
    if (u3) cyc3 = 1'b1; else cyc0 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (get_ack(u3)) begin
        lat = k;
        break;
      end
    end
    cyc0 = 1'b0;
    cyc3 = 1'b0;
  endtask

  // Watch n cycles and count acks on the chosen responder.
  task automatic watch_no_ack(input bit u3, input int n, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (get_ack(u3)) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int lat;

    rst = 1'b1; cyc0 = 1'b0; cyc3 = 1'b0;
    adr = '0; dat = '0; sel = '0; we = 1'b0;

    vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h020, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h020, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h020, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0};
    vecs[6]  = '{1'b0, 32'h020, 32'h0,        4'hF, 32'h11BB33DD, 1'b0};
    vecs[7]  = '{1'b1, 32'h000, 32'hCAFEF00D, 4'hF, 32'h11BB33DD, 1'b0};
    vecs[8]  = '{1'b1, 32'h400, 32'h12345678, 4'hF, 32'h11BB33DD, 1'b1};
    vecs[9]  = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h000, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b0, 32'h3FF, 32'h0,        4'hF, 32'h0BADF00D, 1'b0};

    // Reset held for two cycles with cyc low.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("reset%0d ack0", k), ack0, 0);
      chk($sformatf("reset%0d oor0", k), oor0, 0);
      chk($sformatf("reset%0d rdt0", k), rdt0, 32'h0);
      chk($sformatf("reset%0d ack3", k), ack3, 0);
      chk($sformatf("reset%0d rdt3", k), rdt3, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle ack0", ack0, 0);
    chk("idle rdt0", rdt0, 32'h0);

    // Table of WAIT=0 transactions, issued back-to-back.
    for (int i = 0; i < 13; i++) begin
      xact(1'b0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, lat);
      $display("vec %0d we=%0d adr=%h dat=%h sel=%h lat=%0d rdt=%h oor=%0d",
               i, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, lat, rdt0, oor0);
      chk($sformatf("vec%0d latency", i), lat, 2);
      chk($sformatf("vec%0d oor", i), oor0, vecs[i].exp_oor);
      chk($sformatf("vec%0d rdt", i), rdt0, vecs[i].exp_rdt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d ack drops", i), ack0, 0);
      chk($sformatf("vec%0d oor drops", i), oor0, 0);
      chk($sformatf("vec%0d rdt holds", i), rdt0, vecs[i].exp_rdt);
    end

    // WAIT=3: write then read, each acked 5 edges after cyc is sampled.
    xact(1'b1, 1'b1, 32'h040, 32'h55AA55AA, 4'hF, lat);
    $display("w3 write adr=040 lat=%0d", lat);
    chk("w3 write latency", lat, 5);
    @(posedge clk); #1;
    xact(1'b1, 1'b0, 32'h040, 32'h0, 4'hF, lat);
    $display("w3 read adr=040 lat=%0d rdt=%h", lat, rdt3);
    chk("w3 read latency", lat, 5);
    chk("w3 read rdt", rdt3, 32'h55AA55AA);
    @(posedge clk); #1;

    // Abort: cyc dropped after two wait cycles.
    adr = 32'h040; dat = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    cyc3 = 1'b0;
    $display("w3 abort write adr=040");
    watch_no_ack(1'b1, 8, "abort no ack");
    chk("abort rdt unchanged", rdt3, 32'h55AA55AA);
    xact(1'b1, 1'b0, 32'h040, 32'h0, 4'hF, lat);
    $display("w3 read after abort lat=%0d rdt=%h", lat, rdt3);
    chk("abort readback latency", lat, 5);
    chk("abort readback rdt", rdt3, 32'h55AA55AA);
    @(posedge clk); #1;

    // Reset while a write sits in WAIT.
    adr = 32'h040; dat = 32'h12121212; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc3 = 1'b0;
    $display("w3 reset during write adr=040 ack=%0d rdt=%h", ack3, rdt3);
    chk("rst-wait ack", ack3, 0);
    chk("rst-wait rdt", rdt3, 32'h0);
    watch_no_ack(1'b1, 8, "rst-wait no ack");
    xact(1'b1, 1'b0, 32'h040, 32'h0, 4'hF, lat);
    $display("w3 read after reset lat=%0d rdt=%h", lat, rdt3);
    chk("rst-wait readback latency", lat, 5);
    chk("rst-wait readback rdt", rdt3, 32'h55AA55AA);
    @(posedge clk); #1;
    chk("rst-wait ack drops", ack3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
